// File: rtl/cnn_div_pkg.sv
// Shared widths, saturation limits and FSM encoding for the sequential
// 22s/8ns -> 14s divider and the W14 requantizers built around it.
package cnn_div_pkg;

    localparam int DIN0_W = 22;
    localparam int DIN1_W = 8;
    localparam int DOUT_W = 14;

    localparam int Q_MAX = 8191;
    localparam int Q_MIN = -8192;

    localparam int CNT_W = $clog2(DIN0_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cnn_div_sat_14s.sv
// Combinational sign-apply and saturation of an unsigned magnitude into the
// signed W14 range; a zero divisor forces the rail selected by the sign.
module cnn_div_sat_14s
    import cnn_div_pkg::*;
#(
    parameter int MAG_W = DIN0_W
) (
    input  logic [MAG_W-1:0]  mag,
    input  logic              sign,
    input  logic              dbz,
    output logic [DOUT_W-1:0] dout,
    output logic              sat
);

    localparam logic [MAG_W-1:0]  POS_LIM  = MAG_W'(Q_MAX);
    localparam logic [MAG_W-1:0]  NEG_LIM  = MAG_W'(-Q_MIN);
    localparam logic [DOUT_W-1:0] DOUT_MAX = DOUT_W'(Q_MAX);
    localparam logic [DOUT_W-1:0] DOUT_MIN = DOUT_W'(Q_MIN);

    logic [DOUT_W-1:0] mag_lo;
    assign mag_lo = mag[DOUT_W-1:0];

    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        dout = mag_lo;
        sat  = 1'b0;
        if (dbz) begin
            dout = sign ? DOUT_MIN : DOUT_MAX;
            sat  = 1'b1;
        end else if (sign) begin
            if (mag > NEG_LIM) begin
                dout = DOUT_MIN;
                sat  = 1'b1;
            end else begin
                dout = -mag_lo;
            end
        end else if (mag > POS_LIM) begin
            dout = DOUT_MAX;
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/cnn_div_seq_22s_8ns.sv
// Restoring sequential divider, one quotient bit per cycle, with the
// ap_start/ap_done block handshake; latency is din0_WIDTH + 1 cycles.
module cnn_div_seq_22s_8ns
    import cnn_div_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_ready,
    output logic                  ap_idle,
    output logic                  ap_done,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  sat,
    output logic                  dbz
);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  sign_q;
    logic [din0_WIDTH-1:0] dvd;
    logic [din1_WIDTH-1:0] div_q;
    logic [din1_WIDTH-1:0] rem;

    logic [din0_WIDTH-1:0] din0_mag;
    logic [din1_WIDTH:0]   rem_sh;
    logic [din1_WIDTH-1:0] trial;
    logic                  qbit;
    logic [din1_WIDTH-1:0] rem_nxt;
    logic [din0_WIDTH-1:0] dvd_nxt;
    logic                  div_zero;
    logic [dout_WIDTH-1:0] res_dout;
    logic                  res_sat;

    assign ap_idle  = (state == IDLE);
    assign ap_ready = ap_start & ap_idle;

    // |-2^21| = 2^21 still fits the unsigned din0_WIDTH-bit magnitude.
    assign din0_mag = din0[din0_WIDTH-1] ? -din0 : din0;

    // dvd shifts out dividend bits at the top and collects quotient bits at
    // the bottom, so after the last step it holds the quotient magnitude.
    assign rem_sh   = {rem, dvd[din0_WIDTH-1]};
    assign qbit     = (rem_sh >= {1'b0, div_q});
    assign trial    = din1_WIDTH'(rem_sh - {1'b0, div_q});
    assign rem_nxt  = qbit ? trial : rem_sh[din1_WIDTH-1:0];
    assign dvd_nxt  = {dvd[din0_WIDTH-2:0], qbit};
    assign div_zero = (div_q == '0);

    cnn_div_sat_14s #(.MAG_W(din0_WIDTH)) u_sat (
        .mag  (dvd_nxt),
        .sign (sign_q),
        .dbz  (div_zero),
        .dout (res_dout),
        .sat  (res_sat)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            sign_q  <= 1'b0;
            dvd     <= '0;
            div_q   <= '0;
            rem     <= '0;
            dout    <= '0;
            sat     <= 1'b0;
            dbz     <= 1'b0;
            ap_done <= 1'b0;
        end else begin
            ap_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        state  <= CALC;
                        sign_q <= din0[din0_WIDTH-1];
                        dvd    <= din0_mag;
                        div_q  <= din1;
                        rem    <= '0;
                        cnt    <= CNT_W'(din0_WIDTH - 1);
                    end
                end
                CALC: begin
                    dvd <= dvd_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state   <= DONE;
                        dout    <= res_dout;
                        sat     <= res_sat;
                        dbz     <= div_zero;
                        ap_done <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_div_seq_22s_8ns.sv
// Self-checking bench: integer-division reference model with per-cycle
// handshake/output comparison, plus directed literal cases.
module tb_cnn_div_seq_22s_8ns;

    logic        ap_clk   = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_ready;
    logic        ap_idle;
    logic        ap_done;
    logic [21:0] din0 = '0;
    logic [7:0]  din1 = '0;
    logic [13:0] dout;
    logic        sat;
    logic        dbz;

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    cnn_div_seq_22s_8ns dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .ap_done  (ap_done),
        .din0     (din0),
        .din1     (din1),
        .dout     (dout),
        .sat      (sat),
        .dbz      (dbz)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division (truncates toward zero), then clip.
    task automatic model(input logic [21:0] a, input logic [7:0] b,
                         output int d, output int s, output int z);
        int q;
        if (b == 8'd0) begin
            z = 1;
            s = 1;
            d = ($signed(a) < 0) ? -8192 : 8191;
        end else begin
            z = 0;
            q = int'($signed(a)) / int'(b);
            if (q > 8191) begin
                d = 8191;
                s = 1;
            end else if (q < -8192) begin
                d = -8192;
                s = 1;
            end else begin
                d = q;
                s = 0;
            end
        end
    endtask

    // Per-cycle compare against the model's view of accepts and results.
    int cyc      = 0;
    int done_at  = -1;
    int exp_dout = 0, exp_sat = 0, exp_dbz = 0;
    int pend_dout = 0, pend_sat = 0, pend_dbz = 0;

    always @(negedge ap_clk) begin
        bit busy;
        if (!ap_rst_n) begin
            done_at  = -1;
            exp_dout = 0;
            exp_sat  = 0;
            exp_dbz  = 0;
            check("cmp_rst_idle", int'(ap_idle), 1);
            check("cmp_rst_done", int'(ap_done), 0);
            check("cmp_rst_dout", int'($signed(dout)), 0);
        end else begin
            if (done_at >= 0 && cyc > done_at) done_at = -1;
            busy = (done_at >= 0);
            if (cyc == done_at) begin
                exp_dout = pend_dout;
                exp_sat  = pend_sat;
                exp_dbz  = pend_dbz;
            end
            check("cmp_idle",  int'(ap_idle), int'(!busy));
            check("cmp_ready", int'(ap_ready), int'(ap_start && !busy));
            check("cmp_done",  int'(ap_done), int'(cyc == done_at));
            check("cmp_dout",  int'($signed(dout)), exp_dout);
            check("cmp_sat",   int'(sat), exp_sat);
            check("cmp_dbz",   int'(dbz), exp_dbz);
            if (!busy && ap_start) begin
                model(din0, din1, pend_dout, pend_sat, pend_dbz);
                done_at = cyc + 23;
            end
        end
        cyc++;
    end

    function automatic logic [21:0] rand_a();
        case ($urandom_range(0, 5))
            0:       return 22'h200000;
            1:       return 22'h1FFFFF;
            2:       return 22'd0;
            3:       return 22'($urandom_range(0, 200000));
            default: return 22'($urandom);
        endcase
    endfunction

    function automatic logic [7:0] rand_b();
        case ($urandom_range(0, 9))
            0:       return 8'd0;
            1:       return 8'($urandom_range(1, 4));
            default: return 8'($urandom);
        endcase
    endfunction

    // One transaction; latency is counted from the accept cycle to ap_done.
    task automatic run_op(input logic [21:0] a, input logic [7:0] b, input bit lit,
                          input int ed, input int es, input int ez);
        int k;
        @(posedge ap_clk); #1;
        din0     = a;
        din1     = b;
        ap_start = 1'b1;
        @(negedge ap_clk);
        if (lit) check("ready_on_accept", int'(ap_ready), 1);
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        din0     = 22'($urandom);
        din1     = 8'($urandom);
        k = 0;
        do begin
            @(negedge ap_clk);
            k++;
        end while (!ap_done && k < 40);
        check("done_seen", int'(ap_done), 1);
        check("latency", k, 23);
        if (lit) begin
            check("lit_dout", int'($signed(dout)), ed);
            check("lit_sat",  int'(sat), es);
            check("lit_dbz",  int'(dbz), ez);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!ap_idle && k < 40) begin
            @(negedge ap_clk);
            k++;
        end
        check("reach_idle", int'(ap_idle), 1);
    endtask

    initial begin
        int last_done;
        int n_done;
        int n;

        repeat (3) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        @(negedge ap_clk);
        check("reset_dout", int'($signed(dout)), 0);
        check("reset_flags", int'({sat, dbz, ap_done}), 0);
        check("reset_idle", int'(ap_idle), 1);

        run_op(22'd1000,        8'd7,   1, 142,   0, 0);
        run_op(22'(-1000),      8'd7,   1, -142,  0, 0);
        run_op(22'd100000,      8'd13,  1, 7692,  0, 0);
        run_op(22'd2097151,     8'd1,   1, 8191,  1, 0);
        run_op(22'(-2097152),   8'd255, 1, -8192, 1, 0);
        run_op(22'd500,         8'd0,   1, 8191,  1, 1);
        run_op(22'(-500),       8'd0,   1, -8192, 1, 1);
        run_op(22'd0,           8'd9,   1, 0,     0, 0);
        run_op(22'(-8192*200),  8'd200, 1, -8192, 0, 0);

        // ap_start held high with operands changing every cycle.
        last_done = -1;
        n_done    = 0;
        n         = 0;
        @(posedge ap_clk); #1;
        ap_start = 1'b1;
        din0     = rand_a();
        din1     = rand_b();
        while (n_done < 5 && n < 200) begin
            @(negedge ap_clk);
            if (ap_done) begin
                if (last_done >= 0) check("b2b_spacing", n - last_done, 24);
                last_done = n;
                n_done++;
            end
            @(posedge ap_clk); #1;
            din0 = rand_a();
            din1 = rand_b();
            n++;
        end
        check("b2b_done_count", n_done, 5);
        ap_start = 1'b0;
        @(negedge ap_clk);
        wait_idle();

        // Reset in the middle of CALC aborts the transaction.
        @(posedge ap_clk); #1;
        din0     = 22'd1234;
        din1     = 8'd5;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        repeat (9) @(posedge ap_clk);
        #3 ap_rst_n = 1'b0;
        #1;
        check("abort_dout", int'($signed(dout)), 0);
        check("abort_flags", int'({sat, dbz, ap_done}), 0);
        check("abort_idle", int'(ap_idle), 1);
        @(negedge ap_clk);
        @(posedge ap_clk); #1 ap_rst_n = 1'b1;
        run_op(22'd0, 8'd3, 1, 0, 0, 0);

        repeat (150) begin
            repeat ($urandom_range(0, 3)) @(posedge ap_clk);
            run_op(rand_a(), rand_b(), 0, 0, 0, 0);
        end

        repeat (3) @(negedge ap_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
